// File: rtl/divisor_pkg.sv
// divisor_pkg: shared definitions for the sequential restoring divider.
//   SIZE    - default operand width in bits
//   CNT_W   - iteration counter width for SIZE
//   state_t - controller states IDLE / CALC / DONE (two-bit encoding)
package divisor_pkg;

  // Width of a counter able to index iterations 0 .. n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

  localparam int SIZE  = 32;
  localparam int CNT_W = cnt_width(SIZE);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/div_datapath.sv
// div_datapath: quotient/shift, partial remainder and divisor registers of the
// restoring divider, with the trial subtractor and restore/accept select.
//   clk, reset      - clock, asynchronous active-high reset
//   load            - capture a into Q, b into the divisor register, clear R
//   step            - perform one restoring iteration
//   zero_fix        - divide-by-zero result: Q = all ones, R = captured dividend
//   a, b            - dividend / divisor operands
//   quot, rem       - quotient and remainder (driven straight from registers)
module div_datapath #(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic            zero_fix,
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  output logic [size-1:0] quot,
  output logic [size-1:0] rem
);

  logic [size-1:0] q_r;
  logic [size-1:0] r_r;
  logic [size-1:0] d_r;
  logic [size:0]   shift_s;
  logic [size:0]   diff_s;

  // Trial subtraction on the shifted partial remainder. R is always below the
  // divisor between iterations, so R itself fits in size bits; only the
  // shifted value and the difference need the extra sign bit.
  always_comb begin
    shift_s = {r_r, q_r[size-1]};
    diff_s  = shift_s - {1'b0, d_r};
  end

  // Q / R / divisor registers: load, divide-by-zero fix-up, or one iteration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r <= {size{1'b0}};
      r_r <= {size{1'b0}};
      d_r <= {size{1'b0}};
    end else if (load) begin
      q_r <= a;
      r_r <= {size{1'b0}};
      d_r <= b;
    end else if (zero_fix) begin
      // Q still holds the dividend captured on the load edge.
      q_r <= {size{1'b1}};
      r_r <= q_r;
      d_r <= d_r;
    end else if (step) begin
      if (!diff_s[size]) begin
        r_r <= diff_s[size-1:0];
        q_r <= {q_r[size-2:0], 1'b1};
      end else begin
        r_r <= shift_s[size-1:0];
        q_r <= {q_r[size-2:0], 1'b0};
      end
      d_r <= d_r;
    end else begin
      q_r <= q_r;
      r_r <= r_r;
      d_r <= d_r;
    end
  end

  assign quot = q_r;
  assign rem  = r_r;

endmodule

// File: rtl/divisor.sv
// divisor: sequential restoring divider with valid_data / ret_ack / Done_Flag /
// ack handshake. One quotient bit per clock; result held until acknowledged.
//   clk, reset  - clock, asynchronous active-high reset
//   a, b        - dividend, divisor (sampled on the capture edge only)
//   valid_data  - request; ack - consumer has taken the result
//   quot, rem   - quotient / remainder
//   Done_Flag   - result valid until ack; ret_ack - one-cycle capture pulse
//   div_zero    - current result came from a divide-by-zero request
module divisor
  import divisor_pkg::*;
#(
  parameter int size = SIZE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  input  logic            valid_data,
  input  logic            ack,
  output logic [size-1:0] quot,
  output logic [size-1:0] rem,
  output logic            Done_Flag,
  output logic            ret_ack,
  output logic            div_zero
);

  localparam int CW = cnt_width(size);
  localparam logic [CW-1:0] LAST_CNT = CW'(size - 1);

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic          done_r;
  logic          ret_ack_r;
  logic          div_zero_r;
  logic          zero_pend_r;
  logic          b_zero_s;
  logic          load_s;
  logic          step_s;
  logic          zero_fix_s;

  // Datapath strobes decoded from the current state.
  always_comb begin
    b_zero_s   = (b == {size{1'b0}});
    load_s     = 1'b0;
    step_s     = 1'b0;
    zero_fix_s = 1'b0;
    case (state_r)
      IDLE: begin
        load_s = valid_data;
      end
      CALC: begin
        step_s = 1'b1;
      end
      DONE: begin
        zero_fix_s = zero_pend_r;
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  // Controller: state, iteration counter and registered handshake outputs.
  // A divide-by-zero request enters DONE with zero_pend_r set; that first
  // DONE cycle writes the fixed result and raises Done_Flag, so the result
  // appears one edge after capture and ack cannot be taken before it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      done_r      <= 1'b0;
      ret_ack_r   <= 1'b0;
      div_zero_r  <= 1'b0;
      zero_pend_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ret_ack_r <= valid_data;
          done_r    <= 1'b0;
          if (valid_data) begin
            cnt_r       <= {CW{1'b0}};
            div_zero_r  <= b_zero_s;
            zero_pend_r <= b_zero_s;
            state_r     <= b_zero_s ? DONE : CALC;
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          ret_ack_r <= 1'b0;
          cnt_r     <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_CNT) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= CALC;
          end
        end
        DONE: begin
          ret_ack_r <= 1'b0;
          if (zero_pend_r) begin
            zero_pend_r <= 1'b0;
            done_r      <= 1'b1;
          end else if (ack) begin
            done_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= {CW{1'b0}};
          done_r      <= 1'b0;
          ret_ack_r   <= 1'b0;
          zero_pend_r <= 1'b0;
        end
      endcase
    end
  end

  div_datapath #(
    .size(size)
  ) u_datapath (
    .clk     (clk),
    .reset   (reset),
    .load    (load_s),
    .step    (step_s),
    .zero_fix(zero_fix_s),
    .a       (a),
    .b       (b),
    .quot    (quot),
    .rem     (rem)
  );

  assign Done_Flag = done_r;
  assign ret_ack   = ret_ack_r;
  assign div_zero  = div_zero_r;

endmodule

// File: tb/tb_divisor.sv
// tb_divisor: randomized and directed checks of divisor against an arithmetic
// reference model (/ and %, plus the divide-by-zero rule).
module tb_divisor;

  localparam int SZ = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [SZ-1:0] a;
  logic [SZ-1:0] b;
  logic          valid_data;
  logic          ack;
  logic [SZ-1:0] quot;
  logic [SZ-1:0] rem;
  logic          Done_Flag;
  logic          ret_ack;
  logic          div_zero;

  int vectors     = 0;
  int miscompares = 0;

  divisor dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .valid_data(valid_data),
    .ack       (ack),
    .quot      (quot),
    .rem       (rem),
    .Done_Flag (Done_Flag),
    .ret_ack   (ret_ack),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  function automatic void ref_div(input logic [SZ-1:0] x, input logic [SZ-1:0] y,
                                  output logic [SZ-1:0] q, output logic [SZ-1:0] r,
                                  output logic dz);
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF; r = x; dz = 1'b1;
    end else begin
      q = x / y; r = x % y; dz = 1'b0;
    end
  endfunction

  function automatic logic [SZ-1:0] rand_nz();
    logic [SZ-1:0] v;
    v = $urandom >> $urandom_range(0, 31);
    if (v == 32'd0) v = 32'd1;
    return v;
  endfunction

  // Capture one request and wait for Done_Flag; leaves the DUT in DONE.
  task automatic run_op(input logic [SZ-1:0] a_i, input logic [SZ-1:0] b_i,
                        output int lat, output logic ra_first, output logic ra_later);
    @(negedge clk);
    a = a_i; b = b_i; valid_data = 1'b1;
    @(negedge clk);
    valid_data = 1'b0;
    ra_first = ret_ack;
    ra_later = 1'b0;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (ret_ack) ra_later = 1'b1;
      if (Done_Flag) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic release_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_data = 1'b0; ack = 1'b0; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({quot, rem, Done_Flag, ret_ack, div_zero} !== {67{1'b0}}) begin
      miscompares++;
      $display("FAIL reset_hold: got quot=%h rem=%h done=%b ra=%b dz=%b, need all 0",
               quot, rem, Done_Flag, ret_ack, div_zero);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({quot, rem, Done_Flag, ret_ack, div_zero} !== {67{1'b0}}) begin
      miscompares++;
      $display("FAIL reset_release: got quot=%h rem=%h done=%b ra=%b dz=%b, need all 0",
               quot, rem, Done_Flag, ret_ack, div_zero);
    end
  endtask

  task automatic test_basic();
    int lat; logic ra1, ra2;
    run_op(32'd100, 32'd7, lat, ra1, ra2);
    vectors++;
    if (ra1 !== 1'b1 || ra2 !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_ret_ack: got first=%b later=%b, need 1 0", ra1, ra2);
    end
    vectors++;
    if (lat != 32) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d, need 32", lat);
    end
    vectors++;
    if (quot !== 32'd14 || rem !== 32'd2 || div_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_result: got q=%0d r=%0d dz=%b, need 14 2 0", quot, rem, div_zero);
    end
    release_ack();
    vectors++;
    if (Done_Flag !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done_fall: got %b, need 0", Done_Flag);
    end
  endtask

  task automatic test_directed();
    logic [SZ-1:0] ta [6];
    logic [SZ-1:0] tb [6];
    logic [SZ-1:0] eq, er; logic edz;
    int lat; logic ra1, ra2;
    ta[0] = 32'hFFFF_FFFF; tb[0] = 32'd1;
    ta[1] = 32'd3;         tb[1] = 32'd10;
    ta[2] = 32'hFFFF_FFFF; tb[2] = 32'hFFFF_FFFF;
    ta[3] = 32'h8000_0000; tb[3] = 32'h7FFF_FFFF;
    for (int i = 4; i < 6; i++) begin
      ta[i] = $urandom; tb[i] = rand_nz();
    end
    for (int i = 0; i < 6; i++) begin
      ref_div(ta[i], tb[i], eq, er, edz);
      run_op(ta[i], tb[i], lat, ra1, ra2);
      vectors++;
      if (lat != 32 || quot !== eq || rem !== er || div_zero !== edz) begin
        miscompares++;
        $display("FAIL directed_%0d: %h/%h got lat=%0d q=%h r=%h dz=%b, need 32 %h %h %b",
                 i, ta[i], tb[i], lat, quot, rem, div_zero, eq, er, edz);
      end
      release_ack();
    end
  endtask

  task automatic test_div_zero();
    int lat; logic ra1, ra2;
    run_op(32'd5, 32'd0, lat, ra1, ra2);
    vectors++;
    if (lat != 1 || ra1 !== 1'b1) begin
      miscompares++;
      $display("FAIL dz_latency: got lat=%0d ra=%b, need 1 1", lat, ra1);
    end
    vectors++;
    if (quot !== 32'hFFFF_FFFF || rem !== 32'd5 || div_zero !== 1'b1) begin
      miscompares++;
      $display("FAIL dz_result: got q=%h r=%0d dz=%b, need ffffffff 5 1", quot, rem, div_zero);
    end
    release_ack();
    run_op(32'd9, 32'd3, lat, ra1, ra2);
    vectors++;
    if (lat != 32 || quot !== 32'd3 || rem !== 32'd0 || div_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL dz_next: got lat=%0d q=%0d r=%0d dz=%b, need 32 3 0 0",
               lat, quot, rem, div_zero);
    end
    release_ack();
  endtask

  task automatic test_hold_ack();
    logic [SZ-1:0] xa, xb, eq, er; logic edz;
    int lat; logic ra1, ra2;
    xa = $urandom; xb = rand_nz();
    ref_div(xa, xb, eq, er, edz);
    run_op(xa, xb, lat, ra1, ra2);
    a = $urandom; b = rand_nz(); valid_data = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (Done_Flag !== 1'b1 || ret_ack !== 1'b0 || quot !== eq || rem !== er || div_zero !== edz) begin
        miscompares++;
        $display("FAIL hold_cycle_%0d: got done=%b ra=%b q=%h r=%h, need 1 0 %h %h",
                 i, Done_Flag, ret_ack, quot, rem, eq, er);
      end
    end
    valid_data = 1'b0;
    release_ack();
  endtask

  task automatic test_busy_valid();
    logic [SZ-1:0] a1, b1, a2, b2, eq, er; logic edz;
    int ra_cnt; bit seen;
    a1 = $urandom; b1 = rand_nz(); a2 = $urandom; b2 = rand_nz();
    @(negedge clk);
    a = a1; b = b1; valid_data = 1'b1;
    @(negedge clk);
    a = a2; b = b2;
    ra_cnt = 0; seen = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (ret_ack) ra_cnt++;
      if (Done_Flag) begin seen = 1; break; end
    end
    ref_div(a1, b1, eq, er, edz);
    vectors++;
    if (!seen || ra_cnt != 0 || quot !== eq || rem !== er) begin
      miscompares++;
      $display("FAIL busy_first: got seen=%0d ra_cnt=%0d q=%h r=%h, need 1 0 %h %h",
               seen, ra_cnt, quot, rem, eq, er);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    vectors++;
    if (Done_Flag !== 1'b0 || ret_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_ack_edge: got done=%b ra=%b, need 0 0", Done_Flag, ret_ack);
    end
    @(negedge clk);
    valid_data = 1'b0;
    vectors++;
    if (ret_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_recapture: got ret_ack=%b, need 1", ret_ack);
    end
    seen = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (Done_Flag) begin seen = 1; break; end
    end
    ref_div(a2, b2, eq, er, edz);
    vectors++;
    if (!seen || quot !== eq || rem !== er) begin
      miscompares++;
      $display("FAIL busy_second: got seen=%0d q=%h r=%h, need 1 %h %h", seen, quot, rem, eq, er);
    end
    release_ack();
  endtask

  task automatic test_reset_mid();
    int lat; logic ra1, ra2;
    @(negedge clk);
    a = 32'hDEAD_BEEF; b = 32'd3; valid_data = 1'b1;
    @(negedge clk);
    valid_data = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if ({quot, rem, Done_Flag, ret_ack, div_zero} !== {67{1'b0}}) begin
      miscompares++;
      $display("FAIL reset_mid: got quot=%h rem=%h done=%b ra=%b dz=%b, need all 0",
               quot, rem, Done_Flag, ret_ack, div_zero);
    end
    @(negedge clk);
    reset = 1'b0;
    run_op(32'd1000, 32'd10, lat, ra1, ra2);
    vectors++;
    if (lat != 32 || quot !== 32'd100 || rem !== 32'd0 || div_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_after: got lat=%0d q=%0d r=%0d dz=%b, need 32 100 0 0",
               lat, quot, rem, div_zero);
    end
    release_ack();
  endtask

  task automatic test_back_to_back();
    logic [SZ-1:0] cap_a, cap_b, eq, er; logic edz;
    int got, last; bit prev_done;
    longint unsigned recon;
    got = 0; last = -1; prev_done = 0;
    cap_a = 32'd0; cap_b = 32'd1;
    @(negedge clk);
    a = $urandom; b = rand_nz(); ack = 1'b1; valid_data = 1'b1;
    for (int cyc = 0; cyc < 600 && got < 8; cyc++) begin
      @(negedge clk);
      if (prev_done) begin
        vectors++;
        if (Done_Flag !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_pulse_width: got done=%b one cycle after pulse, need 0", Done_Flag);
        end
      end
      if (ret_ack) begin
        cap_a = a; cap_b = b;
        a = $urandom; b = rand_nz();
      end
      if (Done_Flag) begin
        ref_div(cap_a, cap_b, eq, er, edz);
        recon = longint'(quot) * longint'(cap_b) + longint'(rem);
        vectors++;
        if (recon != longint'(cap_a) || rem >= cap_b || quot !== eq || rem !== er) begin
          miscompares++;
          $display("FAIL b2b_result_%0d: %h/%h got q=%h r=%h, need %h %h",
                   got, cap_a, cap_b, quot, rem, eq, er);
        end
        if (last >= 0) begin
          vectors++;
          if (cyc - last != 34) begin
            miscompares++;
            $display("FAIL b2b_period: got %0d, need 34", cyc - last);
          end
        end
        last = cyc;
        got++;
      end
      prev_done = Done_Flag;
    end
    vectors++;
    if (got < 8) begin
      miscompares++;
      $display("FAIL b2b_timeout: got %0d results, need 8", got);
    end
    ack = 1'b0; valid_data = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_div_zero();
    test_hold_ack();
    test_busy_valid();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
